// File: rtl/pixel_streamer.sv
// Raster-order pixel reader: fetches one pixel per PERIOD clocks from a
// synchronous-read RAM and presents it on din with a one-cycle i_en strobe.
module pixel_streamer #(
   parameter int unsigned AW     = 18,
   parameter int unsigned NPIX   = 262144,
   parameter int unsigned PERIOD = 26,
   parameter int unsigned PW     = 8,
   parameter int unsigned DW     = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          stall,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [PW-1:0] mem_data,
   output logic [DW-1:0] din,
   output logic          i_en,
   output logic          busy,
   output logic          done,
   output logic [AW:0]   pix_cnt
);

   localparam int unsigned CW       = $clog2(PERIOD + 1);
   localparam logic [AW:0]   LAST_CNT = (AW+1)'(NPIX - 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(PERIOD - 1);

   if (PERIOD < 3) begin : g_bad_period
      $error("pixel_streamer: PERIOD must be >= 3");
   end

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      EMIT,
      GAP
   } state_t;

   state_t        state_q, state_d;
   logic          mem_rd_q, mem_rd_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] din_q, din_d;
   logic          i_en_q, i_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW:0]   pix_cnt_q, pix_cnt_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Next-state and output logic; the period counter is loaded at each fetch
   // and counts down freely until it parks at zero in ISSUE.
   always_comb begin
      state_d   = state_q;
      mem_rd_d  = 1'b0;
      addr_d    = addr_q;
      din_d     = '0;
      i_en_d    = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pix_cnt_d = pix_cnt_q;
      cnt_d     = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;

      case (state_q)
         IDLE: begin
            // busy still set here means the last pixel was just emitted
            if (busy_q) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else if (start) begin
               busy_d    = 1'b1;
               pix_cnt_d = '0;
               addr_d    = '0;
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            if (!stall) begin
               mem_rd_d = 1'b1;
               cnt_d    = CNT_LOAD;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            state_d = EMIT;
         end
         EMIT: begin
            din_d     = DW'(mem_data);
            i_en_d    = 1'b1;
            pix_cnt_d = pix_cnt_q + (AW+1)'(1);
            if (pix_cnt_q == LAST_CNT) begin
               state_d = IDLE;
            end else begin
               addr_d = addr_q + AW'(1);
               // the shortest period leaves no room for a GAP cycle
               state_d = (cnt_q == CW'(1)) ? ISSUE : GAP;
            end
         end
         GAP: begin
            if (cnt_q == CW'(1)) begin
               state_d = ISSUE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         mem_rd_q  <= 1'b0;
         addr_q    <= '0;
         din_q     <= '0;
         i_en_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pix_cnt_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mem_rd_q  <= mem_rd_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         i_en_q    <= i_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pix_cnt_q <= pix_cnt_d;
         cnt_q     <= cnt_d;
      end
   end

   assign mem_rd   = mem_rd_q;
   assign mem_addr = addr_q;
   assign din      = din_q;
   assign i_en     = i_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign pix_cnt  = pix_cnt_q;

endmodule

// File: tb/tb_pixel_streamer.sv
// Scoreboard bench for pixel_streamer: a schedule model predicts every fetch,
// strobe and done pulse; a negedge monitor compares what the DUT presents.
module tb_pixel_streamer;

   localparam int unsigned AW     = 3;
   localparam int unsigned NPIX   = 6;
   localparam int unsigned PERIOD = 5;
   localparam int unsigned PW     = 8;
   localparam int unsigned DW     = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          mem_rd;
   logic [AW-1:0] mem_addr;
   logic [PW-1:0] mem_data;
   logic [DW-1:0] din;
   logic          i_en;
   logic          busy;
   logic          done;
   logic [AW:0]   pix_cnt;

   logic [PW-1:0] ram [2**AW];

   pixel_streamer #(
      .AW(AW), .NPIX(NPIX), .PERIOD(PERIOD), .PW(PW), .DW(DW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .stall(stall),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .din(din), .i_en(i_en), .busy(busy), .done(done), .pix_cnt(pix_cnt)
   );

   always #5 clk = ~clk;

   // Synchronous-read image RAM
   always @(posedge clk) begin
      if (mem_rd) mem_data <= ram[mem_addr];
   end

   typedef struct {int cyc; logic [AW-1:0] addr;} rd_t;
   typedef struct {int cyc; logic [DW-1:0] din; logic [AW:0] cnt;} ien_t;

   rd_t  rd_q[$];
   ien_t ien_q[$];
   int   done_q[$];

   int checks = 0, errors = 0;
   int cyc = 0, zero_cyc = -1;
   bit m_busy = 1'b0, busy_exp = 1'b0;
   int m_k = 0, m_due = 0, m_idle_from = 0, clear_at = -1;
   int done_seen = 0;

   // Reference schedule: a frame fetches pixel k at the first edge at or after
   // its due time with stall low; each fetch makes the next one due PERIOD later.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            m_busy = 1'b0; busy_exp = 1'b0; clear_at = -1;
            m_idle_from = cyc + 1; zero_cyc = cyc;
            rd_q.delete(); ien_q.delete(); done_q.delete();
         end else begin
            if (cyc == clear_at) busy_exp = 1'b0;
            if (!m_busy) begin
               if (start && cyc >= m_idle_from) begin
                  m_busy = 1'b1; busy_exp = 1'b1; clear_at = -1;
                  m_k = 0; m_due = cyc + 1;
               end
            end else if (cyc >= m_due && !stall) begin
               rd_q.push_back('{cyc, AW'(m_k)});
               ien_q.push_back('{cyc + 2, DW'(ram[m_k]), (AW+1)'(m_k + 1)});
               m_due = cyc + PERIOD;
               m_k++;
               if (m_k == NPIX) begin
                  m_busy = 1'b0;
                  clear_at = cyc + 3;
                  m_idle_from = cyc + 4;
                  done_q.push_back(cyc + 3);
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever the DUT presents a pulse
   initial begin
      rd_t  re;
      ien_t ie;
      int   de;
      forever begin
         @(negedge clk);
         if (cyc == zero_cyc) begin
            checks++;
            if ({mem_rd, mem_addr, din, i_en, busy, done, pix_cnt} != '0) begin
               errors++;
               $display("FAIL reset_outputs cyc=%0d got rd=%b addr=%0d din=%h ien=%b busy=%b done=%b cnt=%0d, want all zero",
                        cyc, mem_rd, mem_addr, din, i_en, busy, done, pix_cnt);
            end
         end
         checks++;
         if (busy !== busy_exp) begin
            errors++;
            $display("FAIL busy cyc=%0d got %b want %b", cyc, busy, busy_exp);
         end
         checks++;
         if (!i_en && din !== '0) begin
            errors++;
            $display("FAIL din_idle cyc=%0d got %h want 0", cyc, din);
         end

         if (mem_rd) begin
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL rd_unexpected cyc=%0d addr=%0d, want no read", cyc, mem_addr);
            end else begin
               re = rd_q.pop_front();
               if (re.cyc != cyc || re.addr !== mem_addr) begin
                  errors++;
                  $display("FAIL rd cyc=%0d addr=%0d, want cyc=%0d addr=%0d", cyc, mem_addr, re.cyc, re.addr);
               end
            end
         end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
            checks++; errors++;
            re = rd_q.pop_front();
            $display("FAIL rd_missing cyc=%0d got none, want read at cyc=%0d addr=%0d", cyc, re.cyc, re.addr);
         end

         if (i_en) begin
            checks++;
            if (ien_q.size() == 0) begin
               errors++;
               $display("FAIL ien_unexpected cyc=%0d din=%h, want no strobe", cyc, din);
            end else begin
               ie = ien_q.pop_front();
               if (ie.cyc != cyc || ie.din !== din || ie.cnt !== pix_cnt) begin
                  errors++;
                  $display("FAIL ien cyc=%0d din=%h cnt=%0d, want cyc=%0d din=%h cnt=%0d",
                           cyc, din, pix_cnt, ie.cyc, ie.din, ie.cnt);
               end
            end
         end else if (ien_q.size() > 0 && ien_q[0].cyc <= cyc) begin
            checks++; errors++;
            ie = ien_q.pop_front();
            $display("FAIL ien_missing cyc=%0d got none, want strobe at cyc=%0d din=%h", cyc, ie.cyc, ie.din);
         end

         if (done) begin
            checks++;
            done_seen++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done_unexpected cyc=%0d, want no done", cyc);
            end else begin
               de = done_q.pop_front();
               if (de != cyc || pix_cnt !== (AW+1)'(NPIX)) begin
                  errors++;
                  $display("FAIL done cyc=%0d cnt=%0d, want cyc=%0d cnt=%0d", cyc, pix_cnt, de, NPIX);
               end
            end
         end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
            checks++; errors++;
            de = done_q.pop_front();
            $display("FAIL done_missing cyc=%0d got none, want done at cyc=%0d", cyc, de);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic fill_ram();
      for (int i = 0; i < 2**AW; i++) ram[i] = PW'($urandom);
   endtask

   task automatic drain(input int budget);
      int i = 0;
      while ((m_busy || busy_exp || rd_q.size() != 0 || ien_q.size() != 0 || done_q.size() != 0)
             && i < budget) begin
         @(negedge clk);
         i++;
      end
      if (i >= budget) begin
         checks++; errors++;
         $display("FAIL drain_timeout cyc=%0d busy=%b, want frame complete within %0d cycles", cyc, busy, budget);
      end
   endtask

   initial begin
      fill_ram();
      rst = 1'b1; step(3); rst = 1'b0; step(2);

      // clean frame
      start = 1'b1; step(1); start = 1'b0;
      drain(200);

      // stall bursts inside and outside ISSUE
      start = 1'b1; step(1); start = 1'b0;
      step(4); stall = 1'b1; step(3); stall = 1'b0;
      step(8); stall = 1'b1; step(5); stall = 1'b0;
      drain(300);

      // reset mid-frame, then a fresh frame
      start = 1'b1; step(1); start = 1'b0;
      step(9); rst = 1'b1; step(1); rst = 1'b0;
      step(5); fill_ram();
      start = 1'b1; step(1); start = 1'b0;
      drain(200);

      // starts during a frame, then start held across done
      start = 1'b1; step(1); start = 1'b0;
      step(3); start = 1'b1; step(1); start = 1'b0;
      step(7); start = 1'b1; step(80); start = 1'b0;
      drain(300);

      // randomized start/stall/reset traffic
      for (int i = 0; i < 4000; i++) begin
         rst   = ($urandom_range(0, 499) == 0);
         start = ($urandom_range(0, 5) == 0);
         stall = ($urandom_range(0, 3) == 0);
         if (!m_busy && !busy_exp && ien_q.size() == 0 && $urandom_range(0, 9) == 0) fill_ram();
         step(1);
      end
      rst = 1'b0; start = 1'b0; stall = 1'b0;
      drain(300);

      checks++;
      if (rd_q.size() + ien_q.size() + done_q.size() != 0) begin
         errors++;
         $display("FAIL leftover got rd=%0d ien=%0d done=%0d pending, want 0",
                  rd_q.size(), ien_q.size(), done_q.size());
      end
      checks++;
      if (done_seen < 5) begin
         errors++;
         $display("FAIL done_count got %0d, want at least 5", done_seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
